// File: rtl/vga_scan_ctrl.sv
// Parametrised VGA scan controller: timing counters, linear framebuffer reads,
// built-in test patterns and a two-stage registered output pipeline.
module vga_scan_ctrl #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_POL   = 0,
  parameter int ADDR_W     = 19,
  parameter int CHECK_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [7:0]        fill_color,
  output logic              fb_rd,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [2:0]        vga_r,
  output logic [2:0]        vga_g,
  output logic [1:0]        vga_b,
  output logic              frame_start,
  output logic              line_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
  localparam logic SP    = (SYNC_POL != 0);

  // Stage 0 state
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] addr_cnt;

  // Stage 1 state
  logic          fb_rd_q;
  logic          vis_s1, hs_s1, vs_s1, fs_s1, ls_s1;
  logic [1:0]    mode_s1;
  logic [HW-1:0] h_s1;
  logic [VW-1:0] v_s1;

  int         h_i, v_i;
  logic       h_vis, v_vis, visible, hs_raw, vs_raw;
  logic       at_origin, h_wrap, v_wrap, last_pix;
  logic [1:0] mode_eff;

  always_comb begin
    h_i       = int'(h_cnt);
    v_i       = int'(v_cnt);
    h_vis     = h_i < H_VISIBLE;
    v_vis     = v_i < V_VISIBLE;
    visible   = h_vis && v_vis;
    hs_raw    = (h_i >= H_VISIBLE + H_FRONT) && (h_i < H_VISIBLE + H_FRONT + H_SYNC);
    vs_raw    = (v_i >= V_VISIBLE + V_FRONT) && (v_i < V_VISIBLE + V_FRONT + V_SYNC);
    at_origin = (h_i == 0) && (v_i == 0);
    h_wrap    = h_i == H_TOTAL - 1;
    v_wrap    = v_i == V_TOTAL - 1;
    last_pix  = (h_i == H_VISIBLE - 1) && (v_i == V_VISIBLE - 1);
    // The frame's first pixel already uses the mode being latched on this edge.
    mode_eff  = at_origin ? mode : mode_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      mode_q   <= '0;
      addr_cnt <= '0;
    end else if (en) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      if (at_origin) mode_q <= mode;
      if (last_pix) addr_cnt <= '0;
      else if (visible) addr_cnt <= addr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_rd_q <= 1'b0;
      fb_addr <= '0;
      vis_s1  <= 1'b0;
      hs_s1   <= 1'b0;
      vs_s1   <= 1'b0;
      fs_s1   <= 1'b0;
      ls_s1   <= 1'b0;
      mode_s1 <= '0;
      h_s1    <= '0;
      v_s1    <= '0;
    end else if (en) begin
      fb_rd_q <= visible && (mode_eff == 2'd0);
      fb_addr <= addr_cnt;
      vis_s1  <= visible;
      hs_s1   <= hs_raw;
      vs_s1   <= vs_raw;
      fs_s1   <= at_origin && visible;
      ls_s1   <= (h_i == 0) && v_vis;
      mode_s1 <= mode_eff;
      h_s1    <= h_cnt;
      v_s1    <= v_cnt;
    end
  end

  // A frozen pipeline must not look like a fresh read request to the memory.
  assign fb_rd = fb_rd_q && en;

  int         bar;
  logic       checker_on;
  logic [7:0] bar_color, color;

  always_comb begin
    bar = int'(h_s1) / BAR_W;
    if (bar > 7) bar = 7;
    case (bar)
      0:       bar_color = 8'hFF;
      1:       bar_color = 8'hFC;
      2:       bar_color = 8'h1F;
      3:       bar_color = 8'h1C;
      4:       bar_color = 8'hE3;
      5:       bar_color = 8'hE0;
      6:       bar_color = 8'h03;
      default: bar_color = 8'h00;
    endcase
    checker_on = (((int'(h_s1) >> CHECK_LOG2) ^ (int'(v_s1) >> CHECK_LOG2)) & 1) != 0;
    case (mode_s1)
      2'd0:    color = fb_data;
      2'd1:    color = bar_color;
      2'd2:    color = checker_on ? 8'hFF : 8'h00;
      default: color = fill_color;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync                 <= ~SP;
      vsync                 <= ~SP;
      de                    <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
      frame_start           <= 1'b0;
      line_start            <= 1'b0;
    end else if (en) begin
      hsync                 <= hs_s1 ? SP : ~SP;
      vsync                 <= vs_s1 ? SP : ~SP;
      de                    <= vis_s1;
      {vga_r, vga_g, vga_b} <= vis_s1 ? color : 8'h00;
      frame_start           <= fs_s1;
      line_start            <= ls_s1;
    end
  end

endmodule
